// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM states and the opcode decoder for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_OR  = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_MOD} md_op_t;
  typedef enum logic [1:0] {CLS_SINGLE, CLS_MULDIV, CLS_ILLEGAL} op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    case (op)
      OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB, OP_SHL, OP_SAR: return CLS_SINGLE;
      OP_MUL, OP_DIV, OP_MOD:                                return CLS_MULDIV;
      default:                                               return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic md_op_t md_sel(input logic [3:0] op);
    case (op)
      OP_MUL:  return MD_MUL;
      OP_DIV:  return MD_DIV;
      default: return MD_MOD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response handshake bundle between an ALU client (master) and the ALU (slave).
interface multicycle_alu_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             err;

  modport master (
    output in_valid, op, d0, d1, out_ready,
    input  in_ready, out_valid, dout, err
  );

  modport slave (
    input  in_valid, op, d0, d1, out_ready,
    output in_ready, out_valid, dout, err
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// done is raised in the last iteration cycle with result already holding the final step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  md_op_t           op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] acc_nx, mcand_nx, mplier_nx, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, diff;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;
  assign done  = busy && (cnt == CW'(WIDTH - 1));

  // One multiply step and one restoring-division step, computed every cycle.
  always_comb begin
    acc_nx    = mplier[0] ? acc + mcand : acc;
    mcand_nx  = mcand << 1;
    mplier_nx = mplier >> 1;
    rem_sh    = {rem, quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction: quotient rounds toward zero, remainder follows the dividend.
  always_comb begin
    case (op_q)
      MD_MUL:  result = acc_nx;
      MD_DIV:  result = neg_q ? -quo_nx : quo_nx;
      default: result = neg_r ? -rem_nx : rem_nx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      op_q    <= MD_MUL;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      op_q    <= md_op;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      rem     <= '0;
      quo     <= mag_a;
      divisor <= mag_b;
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r   <= a[WIDTH-1];
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      rem    <= rem_nx;
      quo    <= quo_nx;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: logic/add/shift ops finish in one cycle, MUL/DIV/MOD run
// WIDTH cycles in alu_muldiv. Results are held in DONE until consumed.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_alu_if.slave   bus
);

  state_t                  state;
  op_class_t               cls;
  logic                    div_zero, md_start, md_busy, md_done;
  logic                    shamt_big, single_err;
  logic [WIDTH-1:0]        md_result, single_res;
  logic signed [WIDTH-1:0] sar_res;

  assign cls       = op_class(bus.op);
  assign div_zero  = ((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.d1 == '0);
  assign md_start  = (state == IDLE) && bus.in_valid && (cls == CLS_MULDIV) && !div_zero && !md_busy;
  assign shamt_big = (bus.d1 >> SHW) != '0;
  assign sar_res   = $signed(bus.d0) >>> bus.d1[SHW-1:0];

  // Single-cycle results; anything not handled here (illegal op, divide by zero) errors out.
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (bus.op)
      OP_OR:   single_res = bus.d0 | bus.d1;
      OP_XOR:  single_res = bus.d0 ^ bus.d1;
      OP_AND:  single_res = bus.d0 & bus.d1;
      OP_ADD:  single_res = bus.d0 + bus.d1;
      OP_SUB:  single_res = bus.d0 - bus.d1;
      OP_SHL:  single_res = shamt_big ? '0 : bus.d0 << bus.d1[SHW-1:0];
      OP_SAR:  single_res = shamt_big ? {WIDTH{bus.d0[WIDTH-1]}} : sar_res;
      default: single_err = 1'b1;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH), .CW(SHW)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .md_op  (md_sel(bus.op)),
    .a      (bus.d0),
    .b      (bus.d1),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (md_start) begin
              state <= CALC;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.dout      <= single_res;
              bus.err       <= single_err;
            end
          end
        end
        CALC: begin
          if (md_done) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.dout      <= md_result;
            bus.err       <= 1'b0;
          end
        end
        DONE: begin
          // in_ready only rises after the result leaves, so a consume cycle never accepts.
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: a 32-bit instance driven by directed and
// random requests, plus an 8-bit instance for short-latency and reset checks.
module tb_multicycle_alu;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] dout;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   nchecks;
  int   nfail;
  int   rdy_mode;
  bit   shown;
  exp_t sbq[$];
  exp_t mon_e;

  multicycle_alu_if #(.WIDTH(32)) bus ();
  multicycle_alu_if #(.WIDTH(8))  bus8 ();

  multicycle_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_alu #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour in plain signed arithmetic on 64-bit integers.
  function automatic logic [64:0] ref_model(input int w, input logic [3:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb, r;
    logic [63:0] ub, mask;
    logic        e;
    mask = (64'd1 << w) - 64'd1;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb   = $signed(b << (64 - w)) >>> (64 - w);
    ub   = b & mask;
    e    = 1'b0;
    r    = 0;
    case (o)
      4'h0: r = sa | sb;
      4'h1: r = sa ^ sb;
      4'h2: r = sa & sb;
      4'h4: r = sa + sb;
      4'h5: r = sa - sb;
      4'h6: r = sa * sb;
      4'h8: if (ub >= 64'(w)) r = 0; else r = sa << ub;
      4'h9: if (ub >= 64'(w)) r = (sa < 0) ? -1 : 0; else r = sa >>> ub;
      4'hA: if (sb == 0) e = 1'b1; else r = sa / sb;
      4'hB: if (sb == 0) e = 1'b1; else r = sa % sb;
      default: e = 1'b1;
    endcase
    return {e, 64'(r) & mask};
  endfunction

  function automatic int exp_lat(input int w, input logic [3:0] o, input logic [63:0] b);
    if (o == 4'h6) return w + 1;
    if ((o == 4'hA || o == 4'hB) && b != 64'd0) return w + 1;
    return 1;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives one request into the 32-bit DUT and queues what must come back.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ed, input logic ee);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      bus.op       = o;
      bus.d0       = a;
      bus.d1       = b;
      bus.in_valid = 1'b1;
      e.dout       = {32'd0, ed};
      e.err        = ee;
      e.lat        = exp_lat(32, o, {32'd0, b});
      e.acc_cyc    = cyc;
      sbq.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic applyRandom(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] r;
    r = ref_model(32, o, {32'd0, a}, {32'd0, b});
    applyStimulus(o, a, b, r[31:0], r[64]);
  endtask

  // Monitor: every cycle a result is shown it must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sbq[0];
        if (!shown) begin
          checkOutput("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          shown = 1'b1;
        end
        checkOutput("dout", {32'd0, bus.dout}, mon_e.dout);
        checkOutput("err", 64'(bus.err), 64'(mon_e.err));
        if (bus.out_ready) begin
          void'(sbq.pop_front());
          shown = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Runs one complete request on the 8-bit DUT, checking latency and result.
  task automatic run8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic ee);
    int c0;
    @(negedge clk);
    bus8.op       = o;
    bus8.d0       = a;
    bus8.d1       = b;
    bus8.in_valid = 1'b1;
    c0            = cyc;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    @(negedge clk);
    while (!bus8.out_valid && (cyc - c0) < 40) @(negedge clk);
    checkOutput("w8 latency", 64'(cyc - c0), 64'(exp_lat(8, o, {56'd0, b})));
    checkOutput("w8 dout", {56'd0, bus8.dout}, {56'd0, ed});
    checkOutput("w8 err", 64'(bus8.err), 64'(ee));
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    logic [64:0] r;
    bit          stale;
    int          w;

    nchecks       = 0;
    nfail         = 0;
    shown         = 1'b0;
    rdy_mode      = 2;
    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.d0        = '0;
    bus.d1        = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.op       = 4'h0;
    bus8.d0       = '0;
    bus8.d1       = '0;
    bus8.out_ready = 1'b1;
    rst_n         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset dout", {32'd0, bus.dout}, 64'd0);
    checkOutput("reset err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;

    // Directed values, first one accepted at the first edge after reset release.
    applyStimulus(OP_ADD, 32'd3, 32'd7, 32'd10, 1'b0);
    checkOutput("in_ready low after accept", 64'(bus.in_ready), 64'd0);
    applyStimulus(OP_SAR, -32'sd1024, 32'd8, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(OP_SAR, -32'sd1024, 32'd40, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(OP_SHL, 32'd3, 32'd7, 32'd384, 1'b0);
    applyStimulus(OP_SHL, 32'd3, 32'd32, 32'd0, 1'b0);
    applyStimulus(OP_MUL, -32'sd6, 32'd7, 32'hFFFF_FFD6, 1'b0);
    applyStimulus(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(OP_MOD, -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    applyStimulus(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    applyStimulus(OP_DIV, 32'd5, 32'd0, 32'd0, 1'b1);
    applyStimulus(OP_MOD, 32'd5, 32'd0, 32'd0, 1'b1);
    applyStimulus(4'h3, 32'd12, 32'd34, 32'd0, 1'b1);
    applyStimulus(4'hF, 32'd1, 32'd1, 32'd0, 1'b1);

    // Backpressure: result must sit in DONE, unchanged, until out_ready rises.
    applyRandom(OP_MUL, rnd32(), rnd32());
    rdy_mode = 1;
    w = 0;
    @(negedge clk);
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp out_valid held", 64'(bus.out_valid), 64'd1);
      checkOutput("bp in_ready low", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    rdy_mode = 2;
    @(posedge clk);
    #2;
    checkOutput("bp still done", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #2;
    checkOutput("bp idle after release", 64'(bus.in_ready), 64'd1);
    checkOutput("bp out_valid cleared", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply: nothing may come out afterwards.
    applyRandom(OP_MUL, rnd32(), rnd32());
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midreset dout", {32'd0, bus.dout}, 64'd0);
    sbq.delete();
    shown = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    checkOutput("no stale result", 64'(stale), 64'd0);

    // Random traffic with random consumer stalls.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = rnd32();
      b = rnd32();
      if ((o == OP_SHL || o == OP_SAR) && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 40));
      applyRandom(o, a, b);
    end
    rdy_mode = 2;
    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);

    // 8-bit instance: multicycle latency is WIDTH+1 = 9.
    run8(OP_MUL, 8'hFA, 8'd7, 8'hD6, 1'b0);
    run8(OP_DIV, 8'hF9, 8'd2, 8'hFD, 1'b0);
    run8(OP_MOD, 8'hF9, 8'd2, 8'hFF, 1'b0);
    run8(OP_DIV, 8'h80, 8'hFF, 8'h80, 1'b0);
    run8(OP_ADD, 8'd100, 8'd100, 8'hC8, 1'b0);
    run8(OP_SAR, 8'h80, 8'd10, 8'hFF, 1'b0);
    run8(OP_DIV, 8'd5, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      o = 4'($urandom_range(0, 15));
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(0, 255));
      r = ref_model(8, o, {32'd0, a}, {32'd0, b});
      run8(o, a[7:0], b[7:0], r[7:0], r[64]);
    end

    @(negedge clk);
    bus8.op       = OP_MUL;
    bus8.d0       = 8'd13;
    bus8.d1       = 8'd11;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("w8 midreset out_valid", 64'(bus8.out_valid), 64'd0);
    checkOutput("w8 midreset in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.out_valid) stale = 1'b1;
    end
    checkOutput("w8 no stale result", 64'(stale), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
